// File: rtl/vga_fetch.sv
// VGA 640x480 timing generator with Mac-style framebuffer fetch.
// Produces registered syncs and blanking, and fetches one VRAM byte per
// 8-pixel slot into a parallel register for a downstream shift register.
// Every output flop is computed from the *next* counter position, so all
// registered outputs line up with the hcount/vcount registers in the same cycle.
// H_START must be at least 8 so the fetch window can open one slot early.

module vga_fetch #(
    parameter int unsigned H_START     = 64,
    parameter int unsigned V_START     = 69,
    parameter int unsigned MAC_W_BYTES = 64,
    parameter int unsigned MAC_LINES   = 342
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [7:0]  vramData,
    output logic [14:0] vramAddr,
    output logic        nVramRd,
    output logic [7:0]  parOut,
    output logic        nLoad,
    output logic        nHSync,
    output logic        nVSync,
    output logic        nBlank
);

    // 640x480@60 raster constants
    localparam logic [9:0] HLast   = 10'd799;
    localparam logic [9:0] VLast   = 10'd524;
    localparam logic [9:0] HVis    = 10'd640;
    localparam logic [9:0] VVis    = 10'd480;
    localparam logic [9:0] HsStart = 10'd656;
    localparam logic [9:0] HsEnd   = 10'd752;
    localparam logic [9:0] VsStart = 10'd490;
    localparam logic [9:0] VsEnd   = 10'd492;

    // Fetch runs one slot ahead of the displayed pixel, so the window opens 8 early
    localparam logic [9:0]  WinStart  = 10'(H_START - 8);
    localparam logic [9:0]  WinEnd    = 10'(H_START + 8 * MAC_W_BYTES - 8);
    localparam logic [9:0]  LineStart = 10'(V_START);
    localparam logic [9:0]  LineEnd   = 10'(V_START + MAC_LINES);
    localparam logic [14:0] AddrLast  = 15'(MAC_LINES * MAC_W_BYTES - 1);

    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  par_q, par_d;
    logic        nrd_q, nrd_d;
    logic        nld_q, nld_d;
    logic        nhs_q, nhs_d;
    logic        nvs_q, nvs_d;
    logic        nblank_q, nblank_d;
    logic        line_act_d;
    logic        win_d;
    logic        latch;
    logic        frame_wrap;

    // Raster counters: hcount 0..799, vcount advances on each hcount wrap
    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == HLast) begin
            hcount_d = '0;
            vcount_d = (vcount_q == VLast) ? 10'd0 : vcount_q + 10'd1;
        end
    end

    // Decode output levels for the position the counters move to next
    always_comb begin
        line_act_d = (vcount_d >= LineStart) && (vcount_d < LineEnd);
        win_d      = line_act_d && (hcount_d >= WinStart) && (hcount_d < WinEnd);
        nrd_d      = !(win_d && ((hcount_d[2:0] == 3'd5) || (hcount_d[2:0] == 3'd6)));
        nld_d      = !(win_d && (hcount_d[2:0] == 3'd7));
        nhs_d      = !((hcount_d >= HsStart) && (hcount_d < HsEnd));
        nvs_d      = !((vcount_d >= VsStart) && (vcount_d < VsEnd));
        nblank_d   = (hcount_d < HVis) && (vcount_d < VVis);
    end

    // Latch at the end of the second read cycle; address holds at the frame's last byte
    always_comb begin
        latch      = !nrd_q && (hcount_q[2:0] == 3'd6);
        frame_wrap = (hcount_q == HLast) && (vcount_q == VLast);
        addr_d     = addr_q;
        par_d      = par_q;
        if (latch) begin
            par_d = vramData;
        end
        if (frame_wrap) begin
            addr_d = '0;
        end else if (latch && (addr_q != AddrLast)) begin
            addr_d = addr_q + 15'd1;
        end
    end

    // State and output registers; reset aborts any fetch in progress
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hcount_q <= '0;
            vcount_q <= '0;
            addr_q   <= '0;
            par_q    <= '0;
            nrd_q    <= 1'b1;
            nld_q    <= 1'b1;
            nhs_q    <= 1'b1;
            nvs_q    <= 1'b1;
            nblank_q <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            addr_q   <= addr_d;
            par_q    <= par_d;
            nrd_q    <= nrd_d;
            nld_q    <= nld_d;
            nhs_q    <= nhs_d;
            nvs_q    <= nvs_d;
            nblank_q <= nblank_d;
        end
    end

    assign vramAddr = addr_q;
    assign parOut   = par_q;
    assign nVramRd  = nrd_q;
    assign nLoad    = nld_q;
    assign nHSync   = nhs_q;
    assign nVSync   = nvs_q;
    assign nBlank   = nblank_q;

endmodule

// File: doc/vga_fetch.md
VGA_FETCH -- requirements
Module: vga_fetch

Interface
REQ-001 SHALL have parameters: H_START default 64, first Mac pixel column; V_START default 69, first Mac line; MAC_W_BYTES default 64, bytes per Mac line; MAC_LINES default 342, Mac lines per frame.
REQ-002 SHALL have port clk, input, 1, pixel clock (25.175 MHz); all logic on rising edge.
REQ-003 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port vramData, input, 8, byte returned by video RAM.
REQ-005 SHALL have port vramAddr, output, 15, byte address into the current screen buffer.
REQ-006 SHALL have port nVramRd, output, 1, active-low VRAM read strobe.
REQ-007 SHALL have port parOut, output, 8, pixel byte for the downstream shifter's parallel input.
REQ-008 SHALL have port nLoad, output, 1, active-low load strobe for the downstream shifter, sampled on falling clk.
REQ-009 SHALL have ports nHSync, nVSync and nBlank, each output, 1; nBlank is low outside the 640x480 visible area.

Function
REQ-010 hCount (10 bit) SHALL count 0..799 and wrap to 0; vCount (10 bit) SHALL increment when hCount wraps, counting 0..524 and wrapping to 0.
REQ-011 nHSync SHALL be low for hCount 656..751; nVSync SHALL be low for vCount 490..491; all outputs SHALL be registered.
REQ-012 nBlank SHALL be high only when hCount<640 and vCount<480.
REQ-013 A Mac line SHALL be active when V_START<=vCount<V_START+MAC_LINES; the fetch window SHALL be H_START-8<=hCount<H_START+8*MAC_W_BYTES-8 on active lines.
REQ-014 Per 8-pixel slot inside the fetch window, phases SHALL be keyed on hCount[2:0]: 5-6 nVramRd low with vramAddr stable; end of 6 latch vramData into parOut; 7 nLoad low.
REQ-015 nLoad SHALL be low exactly one clock per slot; nVramRd SHALL be high in all other cycles.
REQ-016 Exactly MAC_W_BYTES loads SHALL occur per active line, so the first loaded byte appears on pixel H_START via the shifter.
REQ-017 vramAddr SHALL increment by 1 after each latch, making consecutive lines contiguous at 64 bytes per line.
REQ-018 vramAddr SHALL reset to 0 when vCount wraps to 0, and SHALL never exceed MAC_LINES*MAC_W_BYTES-1 (0x557F).
REQ-019 parOut SHALL hold its last value between latches; outside the window no loads occur, and the shifter drains zeros.
REQ-020 Counter wrap and window edges coinciding in one cycle SHALL obey the hCount/vCount values of that cycle, with no extra or dropped load.

Reset
REQ-021 While nReset is low, hCount, vCount, vramAddr and parOut SHALL be 0; nHSync, nVSync, nVramRd and nLoad SHALL be high; nBlank SHALL be low.
REQ-022 Release of nReset SHALL start counting from hCount=0, vCount=0 on the first rising edge; reset asserted mid-line SHALL abort any fetch immediately, with no partial nLoad pulse.

Verification
REQ-023 Free-run 2 frames -> nHSync period 800 clocks with low width 96; nVSync period 420000 clocks with low width 1600; nBlank high 640 clocks/line on 480 lines.
REQ-024 vCount=69 with a VRAM model returning address[7:0] -> nLoad low at hCount 63,71,...,567 (64 pulses); parOut at the first load is 0x00 and at the last is 0x3F.
REQ-025 Full frame -> 21888 loads total; first address of line 70 is 64; last address 0x557F at vCount 410; vramAddr back to 0 after vCount wraps.
REQ-026 vCount 68 and 411 -> zero nLoad and nVramRd pulses on those lines.
REQ-027 nReset pulsed low at hCount=300, vCount=200 -> all outputs at reset values immediately; after release the first nLoad occurs at vCount 69, hCount 63.
REQ-028 Downstream shifter attached with data 0x80 at address 0 -> shifter output high for exactly one pixel at hCount 64, vCount 69.
